// File: rtl/apb_pkg.sv
// Shared APB types and helpers for the memory completer and the master bench.
// Wait-state insertion in apb_slave_mem is enabled by defining APB_WAIT_EN.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_DATA_W   = 32;
    localparam int APB_ADDR_LSB = 2;

    // Full word index of a byte address; callers range-check before truncating.
    function automatic logic [APB_DATA_W-1:0] word_idx(input logic [APB_DATA_W-1:0] addr);
        return addr >> APB_ADDR_LSB;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module apb_slave_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a register memory, with address error decode.
// Define APB_WAIT_EN to insert WAIT_CYCLES wait states per transfer; otherwise transfers take 2 cycles.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 128,
    parameter int ADDR_LSB    = APB_ADDR_LSB,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] LSB_MASK = DATA_W'((64'd1 << ADDR_LSB) - 64'd1);

    apb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              wcnt_zero;

`ifdef APB_WAIT_EN
    logic [3:0] wcnt_q, wcnt_d;
    assign wcnt_zero = (wcnt_q == 4'd0);
`else
    assign wcnt_zero = 1'b1;
`endif

    logic [DATA_W-1:0] full_idx;
    logic              setup_err;
    logic [DATA_W-1:0] rf_rdata;
    logic              mem_we;

    // Range check uses the untruncated index so out-of-range addresses never alias.
    assign full_idx  = PADDR >> ADDR_LSB;
    assign setup_err = (full_idx >= DATA_W'(DEPTH)) | ((PADDR & LSB_MASK) != '0);

    assign PREADY  = (state_q == ACCESS) & wcnt_zero & PSEL & PENABLE;
    assign PSLVERR = PREADY & addr_err_q;
    assign PRDATA  = prdata_q;
    assign mem_we  = PREADY & pwrite_q & ~addr_err_q & ~PRESET;

    apb_slave_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk   (PCLK),
        .we    (mem_we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (full_idx[IDX_W-1:0]),
        .rdata (rf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pwrite_d   = pwrite_q;
        wdata_d    = wdata_q;
        addr_err_d = addr_err_q;
        prdata_d   = prdata_q;
`ifdef APB_WAIT_EN
        wcnt_d     = wcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d    = ACCESS;
                    idx_d      = full_idx[IDX_W-1:0];
                    pwrite_d   = PWRITE;
                    wdata_d    = PWDATA;
                    addr_err_d = setup_err;
                    // Read happens for writes too; the master ignores PRDATA then.
                    prdata_d   = setup_err ? '0 : rf_rdata;
`ifdef APB_WAIT_EN
                    wcnt_d     = 4'(WAIT_CYCLES);
`endif
                end
            end
            ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    state_d = IDLE;
                end else if (wcnt_zero) begin
                    state_d = IDLE;
                end else begin
`ifdef APB_WAIT_EN
                    wcnt_d = wcnt_q - 4'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pwrite_q   <= 1'b0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
            prdata_q   <= '0;
`ifdef APB_WAIT_EN
            wcnt_q     <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pwrite_q   <= pwrite_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
            prdata_q   <= prdata_d;
`ifdef APB_WAIT_EN
            wcnt_q     <= wcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem; expected latency follows APB_WAIT_EN (WAIT_CYCLES=2).
module tb_apb_slave_mem;

`ifdef APB_WAIT_EN
    localparam int EXP_LAT  = 4;
    localparam int ABORT_AT = 2;
`else
    localparam int EXP_LAT  = 2;
    localparam int ABORT_AT = 1;
`endif

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    apb_slave_mem #(
        .DATA_W      (32),
        .DEPTH       (128),
        .ADDR_LSB    (2),
        .WAIT_CYCLES (2)
    ) dut (
        .PCLK    (pclk),
        .PRESET  (preset),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .PSLVERR (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // abort_at: access cycle (1-based) in which the transfer is aborted, 0 = none.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int abort_at, input logic rst_abort,
                           output logic [31:0] rd, output logic err,
                           output int lat, output logic saw_ready);
        rd = '0; err = 1'b0; lat = 0; saw_ready = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        for (int c = 2; c <= 20; c++) begin
            @(posedge pclk); #1;
            penable = 1'b1;
            paddr   = 32'h0000_0020;
            pwdata  = 32'hA5A5_A5A5;
            pwrite  = ~wr;
            if (c - 1 == abort_at) begin
                if (rst_abort) preset = 1'b1;
                else begin psel = 1'b0; penable = 1'b0; end
            end
            @(negedge pclk);
            if (c - 1 == abort_at) begin
                if (!rst_abort && pready === 1'b1) saw_ready = 1'b1;
                break;
            end
            if (pready === 1'b1) begin
                saw_ready = 1'b1; lat = c; rd = prdata; err = pslverr;
                break;
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        rdy;

        // Reset held 2 cycles while a setup phase is presented.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            if (i == 1) begin
                chk("rst_pready", {31'd0, pready}, 32'd0);
                chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
                chk("rst_prdata", prdata, 32'd0);
            end
            penable = 1'b1;
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
        @(negedge pclk);
        chk("post_rst_pready", {31'd0, pready}, 32'd0);
        chk("post_rst_prdata", prdata, 32'd0);

        do_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, err, lat, rdy);
        chk("wr10_lat", lat, EXP_LAT);
        chk("wr10_err", {31'd0, err}, 32'd0);
        do_xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, rd, err, lat, rdy);
        chk("rd10_lat", lat, EXP_LAT);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_err", {31'd0, err}, 32'd0);

        do_xfer(1'b1, 32'h00, 32'hCAFE_0000, 0, 1'b0, rd, err, lat, rdy);
        chk("wr00_lat", lat, EXP_LAT);
        do_xfer(1'b1, 32'h20, 32'h1111_2222, 0, 1'b0, rd, err, lat, rdy);
        chk("wr20_err", {31'd0, err}, 32'd0);
        do_xfer(1'b1, 32'h24, 32'h3333_4444, 0, 1'b0, rd, err, lat, rdy);
        chk("wr24_err", {31'd0, err}, 32'd0);

        // Index 128 truncates to 0, so a leaked write would land on word 0.
        do_xfer(1'b1, 32'h200, 32'h1, 0, 1'b0, rd, err, lat, rdy);
        chk("wr200_lat", lat, EXP_LAT);
        chk("wr200_err", {31'd0, err}, 32'd1);
        do_xfer(1'b0, 32'h00, 32'h0, 0, 1'b0, rd, err, lat, rdy);
        chk("rd00_data", rd, 32'hCAFE_0000);
        chk("rd00_err", {31'd0, err}, 32'd0);
        do_xfer(1'b0, 32'h200, 32'h0, 0, 1'b0, rd, err, lat, rdy);
        chk("rd200_data", rd, 32'd0);
        chk("rd200_err", {31'd0, err}, 32'd1);

        do_xfer(1'b0, 32'h13, 32'h0, 0, 1'b0, rd, err, lat, rdy);
        chk("rd13_data", rd, 32'd0);
        chk("rd13_err", {31'd0, err}, 32'd1);
        do_xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, rd, err, lat, rdy);
        chk("rd10b_data", rd, 32'hDEAD_BEEF);

        do_xfer(1'b1, 32'h20, 32'h55, ABORT_AT, 1'b0, rd, err, lat, rdy);
        chk("abort_ready", {31'd0, rdy}, 32'd0);
        do_xfer(1'b0, 32'h20, 32'h0, 0, 1'b0, rd, err, lat, rdy);
        chk("rd20_data", rd, 32'h1111_2222);
        chk("rd20_lat", lat, EXP_LAT);

        do_xfer(1'b1, 32'h24, 32'h99, 1, 1'b1, rd, err, lat, rdy);
        chk("rstmid_prdata", prdata, 32'd0);
        chk("rstmid_pready", {31'd0, pready}, 32'd0);
        do_xfer(1'b0, 32'h24, 32'h0, 0, 1'b0, rd, err, lat, rdy);
        chk("rd24_data", rd, 32'h3333_4444);
        chk("rd24_lat", lat, EXP_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
